// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// FSM states, exception causes, funct3 size codes and the default bus timeout.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam int DMEM_TIMEOUT = 255;

    function automatic logic [3:0] ex_cause(input logic is_wr, input logic is_fault);
        logic [3:0] c;
        case ({is_wr, is_fault})
            2'b00:   c = CAUSE_LD_MISALIGN;
            2'b01:   c = CAUSE_LD_FAULT;
            2'b10:   c = CAUSE_ST_MISALIGN;
            default: c = CAUSE_ST_FAULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side controls and data-bus handshake of the access sequencer.
// master = sequencer view, slave = pipeline/bus environment view.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_MemRead;
    logic              i_MemWrite;
    logic              i_atomic;
    logic              i_sc;
    logic [2:0]        i_f3;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_resv_clr;
    logic              o_stall;
    logic              o_done;
    logic [DATA_W-1:0] o_rdata;
    logic              o_ex;
    logic [3:0]        o_ex_cause;
    logic              o_req;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [3:0]        o_be;
    logic [DATA_W-1:0] o_wdata;
    logic              i_ack;
    logic              i_err;
    logic [DATA_W-1:0] i_rdata;

    modport master (
        input  i_MemRead, i_MemWrite, i_atomic, i_sc, i_f3, i_addr, i_wdata, i_resv_clr,
        input  i_ack, i_err, i_rdata,
        output o_stall, o_done, o_rdata, o_ex, o_ex_cause,
        output o_req, o_we, o_addr, o_be, o_wdata
    );

    modport slave (
        output i_MemRead, i_MemWrite, i_atomic, i_sc, i_f3, i_addr, i_wdata, i_resv_clr,
        output i_ack, i_err, i_rdata,
        input  o_stall, o_done, o_rdata, o_ex, o_ex_cause,
        input  o_req, o_we, o_addr, o_be, o_wdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane helper: alignment check, byte enables and store replication for the
// incoming request; shift and sign/zero extension of returned load data. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        req_off,
    input  logic [2:0]        req_f3,
    input  logic              req_atomic,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_misaligned,
    output logic [3:0]        req_be,
    output logic [DATA_W-1:0] req_wdata_rep,
    input  logic [1:0]        rsp_off,
    input  logic [2:0]        rsp_f3,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] rsp_rdata_ext
);
    logic [DATA_W-1:0] shifted;

    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b0000;
        req_wdata_rep  = req_wdata;
        case (req_f3[1:0])
            SZ_BYTE: begin
                req_be        = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_misaligned = req_off[0];
                req_be         = 4'b0011 << req_off;
                req_wdata_rep  = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_misaligned = |req_off;
                req_be         = 4'b1111;
            end
            default: req_misaligned = 1'b1;
        endcase
        // LR/SC are word-only; any other width is reported as misaligned
        if (req_atomic && (req_f3 != F3_WORD)) begin
            req_misaligned = 1'b1;
        end
    end

    always_comb begin
        shifted = rsp_rdata >> {rsp_off, 3'b000};
        case (rsp_f3)
            3'b000:  rsp_rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  rsp_rdata_ext = {24'd0, shifted[7:0]};
            3'b001:  rsp_rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  rsp_rdata_ext = {16'd0, shifted[15:0]};
            default: rsp_rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// EX/MEM data-memory sequencer: IDLE->BUSY->DONE bus handshake, pipeline stall, exceptions, LR/SC reservation.
// Ack in the N-th BUSY cycle gives o_done N+1 cycles after acceptance; local completions take 1 cycle.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input logic                i_clk,
    input logic                i_rst,
    dmem_access_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int WRD_W = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              wr_q, wr_d;
    logic              atomic_q, atomic_d;
    logic              ex_q, ex_d;
    logic [3:0]        cause_q, cause_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resv_vld_q, resv_vld_d;
    logic [WRD_W-1:0]  resv_word_q, resv_word_d;

    logic              req;
    logic              req_wr;
    logic              req_misaligned;
    logic              resv_hit_req;
    logic              resv_hit_cur;
    logic              timeout_hit;
    logic [3:0]        req_be;
    logic [DATA_W-1:0] req_wdata_rep;
    logic [DATA_W-1:0] rsp_rdata_ext;

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .req_off        (bus.i_addr[1:0]),
        .req_f3         (bus.i_f3),
        .req_atomic     (bus.i_atomic),
        .req_wdata      (bus.i_wdata),
        .req_misaligned (req_misaligned),
        .req_be         (req_be),
        .req_wdata_rep  (req_wdata_rep),
        .rsp_off        (addr_q[1:0]),
        .rsp_f3         (f3_q),
        .rsp_rdata      (bus.i_rdata),
        .rsp_rdata_ext  (rsp_rdata_ext)
    );

    assign req          = bus.i_MemRead | bus.i_MemWrite | bus.i_atomic;
    assign req_wr       = bus.i_atomic ? bus.i_sc : bus.i_MemWrite;
    assign resv_hit_req = resv_vld_q && (resv_word_q == bus.i_addr[ADDR_W-1:2]);
    assign resv_hit_cur = resv_vld_q && (resv_word_q == addr_q[ADDR_W-1:2]);
    assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        wr_d        = wr_q;
        atomic_d    = atomic_q;
        ex_d        = ex_q;
        cause_d     = cause_q;
        rdata_d     = rdata_q;
        resv_vld_d  = resv_vld_q;
        resv_word_d = resv_word_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d   = bus.i_addr;
                    be_d     = req_be;
                    wdata_d  = req_wdata_rep;
                    f3_d     = bus.i_f3;
                    wr_d     = req_wr;
                    atomic_d = bus.i_atomic;
                    cnt_d    = '0;
                    ex_d     = 1'b0;
                    cause_d  = 4'd0;
                    if (req_misaligned) begin
                        state_d = ST_DONE;
                        ex_d    = 1'b1;
                        cause_d = ex_cause(req_wr, 1'b0);
                    end else if (bus.i_atomic && bus.i_sc && !resv_hit_req) begin
                        state_d = ST_DONE;
                        rdata_d = DATA_W'(1);
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.i_ack) begin
                    state_d = ST_DONE;
                    if (bus.i_err) begin
                        ex_d    = 1'b1;
                        cause_d = ex_cause(wr_q, 1'b1);
                    end else if (!wr_q) begin
                        rdata_d = rsp_rdata_ext;
                        if (atomic_q) begin
                            resv_vld_d  = 1'b1;
                            resv_word_d = addr_q[ADDR_W-1:2];
                        end
                    end else if (atomic_q) begin
                        rdata_d = '0;
                    end else if (resv_hit_cur) begin
                        resv_vld_d = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    ex_d    = 1'b1;
                    cause_d = ex_cause(wr_q, 1'b1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (atomic_q && wr_q) begin
                    resv_vld_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Trap/xRET invalidation beats an LR completing in the same cycle
        if (bus.i_resv_clr) begin
            resv_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            wr_q        <= 1'b0;
            atomic_q    <= 1'b0;
            ex_q        <= 1'b0;
            cause_q     <= '0;
            rdata_q     <= '0;
            resv_vld_q  <= 1'b0;
            resv_word_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            wr_q        <= wr_d;
            atomic_q    <= atomic_d;
            ex_q        <= ex_d;
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
            resv_vld_q  <= resv_vld_d;
            resv_word_q <= resv_word_d;
        end
    end

    assign bus.o_stall    = (state_q == ST_IDLE) ? req : (state_q == ST_BUSY);
    assign bus.o_done     = (state_q == ST_DONE);
    assign bus.o_ex       = (state_q == ST_DONE) && ex_q;
    assign bus.o_ex_cause = (state_q == ST_DONE) ? cause_q : 4'd0;
    assign bus.o_rdata    = rdata_q;
    assign bus.o_req      = (state_q == ST_BUSY);
    assign bus.o_we       = (state_q == ST_BUSY) && wr_q;
    assign bus.o_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.o_be       = be_q;
    assign bus.o_wdata    = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed steps plus randomized accesses against a
// word-level reference model of alignment, lanes, reservation and completion timing.
module tb_dmem_access_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic        m_resv;
    logic [29:0] m_word;
    logic [31:0] m_rdata;

    logic [31:0] obs_be;
    logic [31:0] obs_wd;
    logic [31:0] obs_cause;
    logic [31:0] obs_ex;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dif ();

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (dif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] word);
        longint v;
        v = longint'(word) / (longint'(1) << (8 * off));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101: v = v % 65536;
            default: v = v;
        endcase
        return v[31:0];
    endfunction

    task automatic drop_inputs();
        dif.i_MemRead  = 1'b0;
        dif.i_MemWrite = 1'b0;
        dif.i_atomic   = 1'b0;
        dif.i_sc       = 1'b0;
        dif.i_ack      = 1'b0;
        dif.i_err      = 1'b0;
        dif.i_resv_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        dif.i_resv_clr = 1'b1;
        @(negedge clk);
        dif.i_resv_clr = 1'b0;
        m_resv = 1'b0;
    endtask

    // op: 0 load, 1 store, 2 LR, 3 SC. lat: BUSY cycle that acks, 0 = never ack.
    task automatic access(input int op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat, input logic err,
                          input logic [31:0] rd, input logic clr_ack);
        logic wr, atom, mis, sc_ok, use_bus, exp_ex, unstable;
        logic [31:0] exp_be, exp_wd, exp_cause, snap_addr, snap_be, snap_wd, snap_we;
        int off, size, exp_busy, busy, stall_cnt, done_at;

        wr    = (op == 1) || (op == 3);
        atom  = (op >= 2);
        off   = int'(addr[1:0]);
        size  = int'(f3[1:0]);
        mis   = (atom && f3 != 3'b010) || size == 3 || (size == 1 && off % 2 != 0) || (size == 2 && off != 0);
        sc_ok = m_resv && (m_word == addr[31:2]);
        use_bus  = !mis && !(op == 3 && !sc_ok);
        exp_busy = !use_bus ? 0 : (lat == 0 ? 255 : lat);
        exp_be   = (size == 0) ? 32'(1 << off) : (size == 1) ? 32'(3 << off) : 32'hF;
        exp_wd   = (size == 0) ? 32'(wd[7:0]) * 32'h0101_0101 :
                   (size == 1) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        exp_ex    = mis || (use_bus && (lat == 0 || err));
        exp_cause = mis ? (wr ? 32'd6 : 32'd4) : (wr ? 32'd7 : 32'd5);

        @(negedge clk);
        dif.i_MemRead  = (op == 0);
        dif.i_MemWrite = (op == 1);
        dif.i_atomic   = atom;
        dif.i_sc       = (op == 3);
        dif.i_f3       = f3;
        dif.i_addr     = addr;
        dif.i_wdata    = wd;
        dif.i_ack      = 1'($urandom_range(0, 1));
        dif.i_err      = 1'($urandom_range(0, 1));
        busy = 0; stall_cnt = 0; done_at = 0; unstable = 1'b0;
        snap_addr = '0; snap_be = '0; snap_wd = '0; snap_we = '0;

        for (int c = 0; c <= 300 && done_at == 0; c++) begin
            #1;
            if (dif.o_stall) stall_cnt++;
            if (dif.o_done) begin
                done_at   = c;
                obs_ex    = 32'(dif.o_ex);
                obs_cause = 32'(dif.o_ex_cause);
                drop_inputs();
            end else if (dif.o_req) begin
                busy++;
                if (busy == 1) begin
                    snap_we = 32'(dif.o_we); snap_addr = dif.o_addr;
                    snap_be = 32'(dif.o_be); snap_wd = dif.o_wdata;
                end else if (snap_we != 32'(dif.o_we) || snap_addr != dif.o_addr ||
                             snap_be != 32'(dif.o_be) || snap_wd != dif.o_wdata) begin
                    unstable = 1'b1;
                end
                dif.i_ack      = (busy == lat);
                dif.i_err      = (busy == lat) && err;
                dif.i_rdata    = (busy == lat) ? rd : $urandom;
                dif.i_resv_clr = (busy == lat) && clr_ack;
            end else begin
                dif.i_ack = 1'($urandom_range(0, 1));
            end
            if (done_at == 0) @(negedge clk);
        end

        obs_be = snap_be;
        obs_wd = snap_wd;
        chk("done_latency", 32'(done_at), 32'(exp_busy + 1));
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_busy + 1));
        chk("busy_cycles", 32'(busy), 32'(exp_busy));
        if (exp_busy > 0) begin
            chk("bus_we", snap_we, 32'(wr));
            chk("bus_addr", snap_addr, {addr[31:2], 2'b00});
            chk("bus_be", snap_be, exp_be);
            if (wr) chk("bus_wdata", snap_wd, exp_wd);
            chk("bus_stable", 32'(unstable), 32'd0);
        end
        chk("ex_flag", obs_ex, 32'(exp_ex));
        if (exp_ex) chk("ex_cause", obs_cause, exp_cause);

        if (!exp_ex) begin
            if (op == 0 || op == 2) m_rdata = model_load(f3, off, rd);
            else if (op == 3)       m_rdata = use_bus ? 32'd0 : 32'd1;
        end
        if (op == 2 && !exp_ex) begin
            m_resv = 1'b1;
            m_word = addr[31:2];
        end
        if (op == 1 && !exp_ex && m_resv && m_word == addr[31:2]) m_resv = 1'b0;
        if (op == 3) m_resv = 1'b0;
        if (clr_ack && use_bus && lat > 0) m_resv = 1'b0;
        #1;
        chk("rdata", dif.o_rdata, m_rdata);
    endtask

    initial begin
        int          op, lat;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [29:0] last_lr;
        logic        err, clr;

        checks = 0; failures = 0;
        m_resv = 1'b0; m_word = '0; m_rdata = '0; last_lr = 30'h80;
        obs_be = '0; obs_wd = '0; obs_cause = '0; obs_ex = '0;
        rst = 1'b1;
        drop_inputs();
        dif.i_f3 = 3'b000; dif.i_addr = '0; dif.i_wdata = '0; dif.i_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(dif.o_stall), 32'd0);
        chk("rst_done", 32'(dif.o_done), 32'd0);
        chk("rst_req_we", {30'd0, dif.o_req, dif.o_we}, 32'd0);
        chk("rst_ex", {27'd0, dif.o_ex, dif.o_ex_cause}, 32'd0);
        chk("rst_rdata", dif.o_rdata, 32'd0);
        chk("rst_addr", dif.o_addr, 32'd0);
        chk("rst_be_wdata", dif.o_wdata | 32'(dif.o_be), 32'd0);
        rst = 1'b0;

        // Directed cases
        access(0, 3'b010, 32'h100, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("lw_be", obs_be, 32'hF);
        chk("lw_rdata", dif.o_rdata, 32'hDEAD_BEEF);
        access(0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 32'h8012_3456, 1'b0);
        chk("lb_be", obs_be, 32'h8);
        chk("lb_rdata", dif.o_rdata, 32'hFFFF_FF80);
        access(0, 3'b100, 32'h103, 32'h0, 2, 1'b0, 32'h8012_3456, 1'b0);
        chk("lbu_rdata", dif.o_rdata, 32'h0000_0080);
        access(1, 3'b001, 32'h102, 32'h1234, 2, 1'b0, 32'h0, 1'b0);
        chk("sh_be", obs_be, 32'hC);
        chk("sh_wdata", obs_wd, 32'h1234_1234);
        access(1, 3'b001, 32'h101, 32'h1234, 2, 1'b0, 32'h0, 1'b0);
        chk("sh_mis_cause", obs_cause, 32'd6);
        access(2, 3'b010, 32'h200, 32'h0, 2, 1'b0, 32'h1111_2222, 1'b0);
        access(3, 3'b010, 32'h200, 32'hCAFE, 1, 1'b0, 32'h0, 1'b0);
        chk("sc_ok_rdata", dif.o_rdata, 32'd0);
        access(3, 3'b010, 32'h200, 32'hCAFE, 1, 1'b0, 32'h0, 1'b0);
        chk("sc_again_rdata", dif.o_rdata, 32'd1);
        access(2, 3'b010, 32'h200, 32'h0, 1, 1'b0, 32'h3333_4444, 1'b0);
        pulse_clr();
        access(3, 3'b010, 32'h200, 32'hCAFE, 1, 1'b0, 32'h0, 1'b0);
        chk("sc_after_clr", dif.o_rdata, 32'd1);
        access(2, 3'b010, 32'h210, 32'h0, 2, 1'b0, 32'h5, 1'b1);
        access(3, 3'b010, 32'h210, 32'hBEEF, 1, 1'b0, 32'h0, 1'b0);
        chk("clr_beats_lr", dif.o_rdata, 32'd1);
        access(0, 3'b010, 32'h180, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        chk("timeout_cause", obs_cause, 32'd5);
        access(1, 3'b010, 32'h184, 32'h7777, 2, 1'b1, 32'h0, 1'b0);
        chk("st_fault_cause", obs_cause, 32'd7);

        // Reset while BUSY abandons the transaction and the reservation
        access(2, 3'b010, 32'h300, 32'h0, 2, 1'b0, 32'h5555_0000, 1'b0);
        @(negedge clk);
        dif.i_MemRead = 1'b1; dif.i_f3 = 3'b010; dif.i_addr = 32'h404; dif.i_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_req", 32'(dif.o_req), 32'd1);
        dif.i_MemRead = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_req", 32'(dif.o_req), 32'd0);
        chk("midrst_stall", 32'(dif.o_stall), 32'd0);
        chk("midrst_rdata", dif.o_rdata, 32'd0);
        rst = 1'b0;
        m_resv = 1'b0; m_rdata = 32'd0;
        access(3, 3'b010, 32'h300, 32'h1, 1, 1'b0, 32'h0, 1'b0);
        chk("midrst_resv_gone", dif.o_rdata, 32'd1);
        access(0, 3'b010, 32'h404, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 1'b0);

        // Randomized accesses
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 3);
            if (op == 0)      f3 = ld_f3[$urandom_range(0, 4)];
            else if (op == 1) f3 = 3'($urandom_range(0, 2));
            else              f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
            addr = $urandom_range(0, 1) ? 32'h200 + 32'(4 * $urandom_range(0, 3)) : {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'($urandom);
            if (op == 3 && $urandom_range(0, 1) == 1) addr = {last_lr, 2'b00};
            if (op == 2) last_lr = addr[31:2];
            lat = ($urandom_range(0, 40) == 0) ? 0 : $urandom_range(1, 5);
            err = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) pulse_clr();
            access(op, f3, addr, $urandom, lat, err, $urandom, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access sequencer for the EX/MEM stage.
- Takes the memory controls produced by main decode, registered in the EX-stage pipeline register, and runs the request/ack handshake on the data bus.
- Holds the pipeline stall until the access completes, and raises alignment and access-fault exceptions.
- Owns the LR/SC reservation for the RV-A atomic path.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- TIMEOUT, 255, maximum BUSY cycles without i_ack before an access fault is raised.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_MemRead  in  1  load request (EX stage).
- i_MemWrite  in  1  store request (EX stage).
- i_atomic  in  1  LR/SC instruction.
- i_sc  in  1  1=SC, 0=LR; qualifies i_atomic only.
- i_f3  in  3  funct3: size/sign.
- i_addr  in  ADDR_W  effective address.
- i_wdata  in  DATA_W  rs2 store data.
- i_resv_clr  in  1  trap/xRET: invalidate reservation.
- o_stall  out  1  freeze pipeline.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  DATA_W  aligned, extended load result, or SC status.
- o_ex  out  1  exception, valid with o_done.
- o_ex_cause  out  4  4=load misaligned, 5=load fault, 6=store misaligned, 7=store fault.
- o_req  out  1  bus request.
- o_we  out  1  bus write.
- o_addr  out  ADDR_W  word-aligned bus address ({addr[31:2],2'b00}).
- o_be  out  4  byte enables.
- o_wdata  out  DATA_W  lane-replicated store data.
- i_ack  in  1  bus completion.
- i_err  in  1  bus error, qualified by i_ack.
- i_rdata  in  DATA_W  bus read data.

Behaviour:
- Reset (synchronous, i_rst=1 at edge):
  - state=IDLE; reservation invalid; counter=0.
  - All outputs 0.
  - An in-flight bus transaction is abandoned: o_req drops next cycle.
- Request condition:
  - req = i_MemRead | i_MemWrite | i_atomic.
  - Direction: atomic uses i_sc only (LR=read, SC=write); otherwise i_MemWrite selects write.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE:
    - o_stall = req (combinational).
    - If req: latch addr, be, wdata, f3 and direction.
      - Misaligned -> DONE with o_ex.
      - SC with no matching reservation -> DONE with rdata=1, no bus cycle.
      - Otherwise -> BUSY.
  - BUSY:
    - o_req=1, o_stall=1; bus outputs held stable; counter increments.
    - i_ack & !i_err -> capture rdata -> DONE.
    - i_ack & i_err -> DONE with fault cause.
    - counter==TIMEOUT-1 without ack -> DONE with fault cause.
    - Ack and timeout in the same cycle: ack wins.
  - DONE:
    - o_done=1, o_stall=0 (pipeline advances this edge); new requests ignored.
    - Unconditional transition to IDLE.
- Latency: ack in the N-th BUSY cycle gives o_done N+1 cycles after request acceptance. A locally completed access (misaligned, failed SC) completes 1 cycle after acceptance.
- Alignment:
  - byte: any address.
  - half: addr[0]=0.
  - word: addr[1:0]=0.
  - Atomics with i_f3!=010 are treated as misaligned (cause 4 for LR, 6 for SC).
- Byte enables:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<addr[1:0].
  - SW: 1111.
- Write data replication: byte 4x, half 2x.
- Load data:
  - Shift i_rdata right by 8*addr[1:0].
  - Extension: f3 000 sign8, 100 zero8, 001 sign16, 101 zero16, 010 word.
  - o_rdata holds its value until the next o_done.
- Reservation (granule = one word, addr[31:2]):
  - Successful LR: valid=1, record word address.
  - SC:
    - Valid and matching -> bus write, rdata=0 on success.
    - Otherwise rdata=1, no bus cycle.
    - A faulting SC returns no status (o_ex only).
    - Every SC clears the reservation at DONE.
  - A plain store completing to the reserved word clears the reservation.
  - i_resv_clr clears the reservation; priority over an LR set in the same cycle.
- i_ack while o_req=0: ignored.

Decomposition:
- Package dmem_pkg: FSM state enum, exception cause constants, funct3 size encodings, TIMEOUT default.
- Sub-module dmem_lane_align (combinational): alignment check, be generation, wdata replication, rdata shift/extend.
- FSM, counter and reservation stay in the top module.

Test Plan:
- LW at 0x100; ack on 3rd BUSY cycle with i_rdata=0xDEADBEEF -> o_stall high 4 cycles; o_done 1 cycle; o_rdata=0xDEADBEEF; o_be=1111.
- LB at 0x103, i_rdata=0x80xxxxxx -> o_be=1000, o_rdata=0xFFFFFF80; same with LBU -> 0x00000080.
- SH at 0x102, wdata=0x1234 -> o_be=1100, o_wdata=0x12341234. SH at 0x101 -> no o_req; o_ex=1, cause=6 one cycle after request.
- LR 0x200, then SC 0x200 -> bus write, o_rdata=0. SC 0x200 again -> no o_req, o_rdata=1. LR 0x200, i_resv_clr, SC 0x200 -> o_rdata=1.
- LW with i_ack never asserted -> o_req drops after 255 BUSY cycles; o_ex=1, cause=5. Ack with i_err on an SW -> cause=7.
- i_rst asserted mid-BUSY -> next cycle o_req=0, o_stall=0, reservation invalid; a following LW completes normally.
